// File: rtl/branch_split_pkg.sv
// Shared types and constants for the branch_split transmitter stage.
package branch_split_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAYER  = 2'd1,
    WAIT   = 2'd2,
    BRANCH = 2'd3
  } state_t;

  localparam int DEFAULT_N             = 8;
  localparam int DEFAULT_INPUT_CHANNEL = 1;
  localparam int W                     = DEFAULT_INPUT_CHANNEL * DEFAULT_N;
  localparam int CW                    = 4;

  function automatic int half_width(input int n, input int channels);
    return n * channels;
  endfunction

endpackage

// File: rtl/branch_split.sv
// Splits one double-width word into a trunk pulse followed, GAP idle cycles
// later, by a branch pulse, so the stream always satisfies the merge stage.
module branch_split
  import branch_split_pkg::*;
#(
  parameter int N             = 8,
  parameter int INPUT_CHANNEL = 1,
  parameter int GAP           = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           din_vld,
  input  logic [2*INPUT_CHANNEL*N-1:0]   din,
  output logic                           din_rdy,
  output logic                           layer_vld,
  output logic [INPUT_CHANNEL*N-1:0]     layer_dout,
  output logic                           branch_vld,
  output logic [INPUT_CHANNEL*N-1:0]     branch_dout,
  output logic                           busy
);

  localparam int HW = half_width(N, INPUT_CHANNEL);
  localparam logic [CW-1:0] GAP_LOAD = (GAP > 0) ? CW'(GAP - 1) : '0;

  state_t          state;
  logic [CW-1:0]   gap_cnt;
  logic [HW-1:0]   hold;
  logic            accept;

  // rst_n is active-high despite its name: ready drops for the whole reset cycle.
  assign din_rdy = ((state == IDLE) || (state == BRANCH)) && !rst_n;
  assign accept  = din_vld && din_rdy;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      hold        <= '0;
      layer_vld   <= 1'b0;
      layer_dout  <= '0;
      branch_vld  <= 1'b0;
      branch_dout <= '0;
    end else begin
      layer_vld  <= 1'b0;
      branch_vld <= 1'b0;
      case (state)
        IDLE, BRANCH: begin
          if (accept) begin
            hold       <= din[2*HW-1:HW];
            layer_dout <= din[HW-1:0];
            layer_vld  <= 1'b1;
            state      <= LAYER;
          end else begin
            state <= IDLE;
          end
        end
        LAYER: begin
          if (GAP > 0) begin
            gap_cnt <= GAP_LOAD;
            state   <= WAIT;
          end else begin
            branch_dout <= hold;
            branch_vld  <= 1'b1;
            state       <= BRANCH;
          end
        end
        WAIT: begin
          if (gap_cnt != '0) begin
            gap_cnt <= gap_cnt - 1'b1;
          end else begin
            branch_dout <= hold;
            branch_vld  <= 1'b1;
            state       <= BRANCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_split.sv
// Scoreboard bench: two instances (GAP=2 and GAP=0) plus a behavioural
// concat model on the GAP=2 instance for the end-to-end check.
module tb_branch_split;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  int          edge_count = 0;
  int          checks = 0;
  int          errors = 0;
  bit          started = 1'b0;

  logic        rst2 = 1'b1, vld2 = 1'b0;
  logic [15:0] din2 = '0;
  logic        rdy2, lvld2, bvld2, busy2;
  logic [7:0]  ldout2, bdout2;

  logic        rst0 = 1'b1, vld0 = 1'b0;
  logic [15:0] din0 = '0;
  logic        rdy0, lvld0, bvld0, busy0;
  logic [7:0]  ldout0, bdout0;

  logic [7:0]  concat_low;
  logic [15:0] concat_dout;
  logic        concat_dout_vld;

  exp_t q_l2[$], q_b2[$], q_l0[$], q_b0[$], q_c[$];

  branch_split #(.N(8), .INPUT_CHANNEL(1), .GAP(2)) u_gap2 (
    .clk(clk), .rst_n(rst2), .din_vld(vld2), .din(din2), .din_rdy(rdy2),
    .layer_vld(lvld2), .layer_dout(ldout2), .branch_vld(bvld2),
    .branch_dout(bdout2), .busy(busy2)
  );

  branch_split #(.N(8), .INPUT_CHANNEL(1), .GAP(0)) u_gap0 (
    .clk(clk), .rst_n(rst0), .din_vld(vld0), .din(din0), .din_rdy(rdy0),
    .layer_vld(lvld0), .layer_dout(ldout0), .branch_vld(bvld0),
    .branch_dout(bdout0), .busy(busy0)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_count <= edge_count + 1;

  // Behavioural concat: remembers the trunk half, joins it with the branch half.
  always @(posedge clk) begin
    if (rst2) begin
      concat_low      <= '0;
      concat_dout     <= '0;
      concat_dout_vld <= 1'b0;
    end else begin
      concat_dout_vld <= 1'b0;
      if (lvld2) concat_low <= ldout2;
      if (bvld2) begin
        concat_dout     <= {bdout2, concat_low};
        concat_dout_vld <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, actual, expected, edge_count);
    end
  endtask

  task automatic pop_check(input int which, input string name, input logic [15:0] data);
    exp_t e;
    bit   empty;
    case (which)
      0: empty = (q_l2.size() == 0);
      1: empty = (q_b2.size() == 0);
      2: empty = (q_l0.size() == 0);
      3: empty = (q_b0.size() == 0);
      default: empty = (q_c.size() == 0);
    endcase
    if (empty) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s unexpected pulse: got %h, expected no pulse (cycle %0d)", name, data, edge_count);
    end else begin
      case (which)
        0: e = q_l2.pop_front();
        1: e = q_b2.pop_front();
        2: e = q_l0.pop_front();
        3: e = q_b0.pop_front();
        default: e = q_c.pop_front();
      endcase
      check({name, "_data"}, data, e.data);
      check({name, "_cycle"}, 16'(edge_count), 16'(e.cyc));
    end
  endtask

  // Monitor: samples on the falling edge, independent of the stimulus thread.
  always @(negedge clk) begin
    if (started) begin
      if (lvld2 || bvld2) check("overlap2", {15'd0, lvld2 & bvld2}, 16'd0);
      if (lvld0 || bvld0) check("overlap0", {15'd0, lvld0 & bvld0}, 16'd0);
      if (lvld2) pop_check(0, "layer2", {8'h00, ldout2});
      if (bvld2) pop_check(1, "branch2", {8'h00, bdout2});
      if (lvld0) pop_check(2, "layer0", {8'h00, ldout0});
      if (bvld0) begin
        pop_check(3, "branch0", {8'h00, bdout0});
        check("rdy_in_branch0", {15'd0, rdy0}, 16'd1);
      end
      if (concat_dout_vld) pop_check(4, "concat", concat_dout);
    end
  end

  // Offers a word (held valid under backpressure) and queues its expected pulses.
  task automatic apply_stimulus(input int sel, input logic [15:0] word,
                                input logic [7:0] exp_layer, input logic [7:0] exp_branch,
                                input bit expect_branch);
    exp_t e;
    int   gap;
    int   tries;
    gap   = (sel == 0) ? 2 : 0;
    tries = 0;
    while (((sel == 0) ? rdy2 : rdy0) !== 1'b1 && tries < 50) begin
      if (sel == 0) begin din2 = word; vld2 = 1'b1; end
      else          begin din0 = word; vld0 = 1'b1; end
      tries++;
      @(negedge clk);
    end
    if (tries >= 50) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got no ready, expected ready within 50 cycles");
      vld2 = 1'b0;
      vld0 = 1'b0;
      return;
    end
    if (sel == 0) begin din2 = word; vld2 = 1'b1; end
    else          begin din0 = word; vld0 = 1'b1; end
    e.data = {8'h00, exp_layer};
    e.cyc  = edge_count + 1;
    if (sel == 0) q_l2.push_back(e); else q_l0.push_back(e);
    if (expect_branch) begin
      e.data = {8'h00, exp_branch};
      e.cyc  = edge_count + 2 + gap;
      if (sel == 0) q_b2.push_back(e); else q_b0.push_back(e);
      if (sel == 0) begin
        e.data = word;
        e.cyc  = edge_count + 3 + gap;
        q_c.push_back(e);
      end
    end
    @(negedge clk);
    vld2 = 1'b0;
    vld0 = 1'b0;
  endtask

  task automatic check_output(input string name);
    int waited;
    waited = 0;
    while ((q_l2.size() + q_b2.size() + q_l0.size() + q_b0.size() + q_c.size()) != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    check({name, "_drained"}, 16'(q_l2.size() + q_b2.size() + q_l0.size() + q_b0.size() + q_c.size()), 16'd0);
    check({name, "_busy2_idle"}, {15'd0, busy2}, 16'd0);
    check({name, "_busy0_idle"}, {15'd0, busy0}, 16'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("reset_rdy2", {15'd0, rdy2}, 16'd0);
    check("reset_rdy0", {15'd0, rdy0}, 16'd0);
    check("reset_outs2", {lvld2, bvld2, busy2, 5'd0, ldout2 | bdout2}, 16'd0);
    check("reset_outs0", {lvld0, bvld0, busy0, 5'd0, ldout0 | bdout0}, 16'd0);
    rst2 = 1'b0;
    rst0 = 1'b0;
    started = 1'b1;
    @(negedge clk);
    check("release_rdy2", {15'd0, rdy2}, 16'd1);
    check("release_rdy0", {15'd0, rdy0}, 16'd1);

    // Single word, GAP=2.
    apply_stimulus(0, 16'hA55A, 8'h5A, 8'hA5, 1'b1);
    check("busy_after_accept", {15'd0, busy2}, 16'd1);
    check_output("single");

    // Back-to-back with valid held; later words wait through LAYER/WAIT.
    apply_stimulus(0, 16'h0201, 8'h01, 8'h02, 1'b1);
    apply_stimulus(0, 16'h0403, 8'h03, 8'h04, 1'b1);
    apply_stimulus(0, 16'h0605, 8'h05, 8'h06, 1'b1);
    check_output("b2b");

    // GAP=0: branch one cycle after layer, period 2.
    apply_stimulus(1, 16'hCC33, 8'h33, 8'hCC, 1'b1);
    apply_stimulus(1, 16'h1122, 8'h22, 8'h11, 1'b1);
    check_output("gap0");

    // Backpressure: a different word offered during WAIT must not disturb the branch half.
    apply_stimulus(0, 16'h7788, 8'h88, 8'h77, 1'b1);
    @(negedge clk);
    din2 = 16'h9966;
    vld2 = 1'b1;
    @(negedge clk);
    check("bp_not_ready", {15'd0, rdy2}, 16'd0);
    apply_stimulus(0, 16'h9966, 8'h66, 8'h99, 1'b1);
    check_output("backpressure");

    // Reset during WAIT drops the in-flight branch half.
    apply_stimulus(0, 16'hF00D, 8'h0D, 8'hF0, 1'b0);
    @(negedge clk);
    rst2 = 1'b1;
    @(negedge clk);
    check("midreset_outs", {lvld2, bvld2, busy2, 5'd0, ldout2 | bdout2}, 16'd0);
    check("midreset_rdy", {15'd0, rdy2}, 16'd0);
    rst2 = 1'b0;
    @(negedge clk);
    apply_stimulus(0, 16'hA55A, 8'h5A, 8'hA5, 1'b1);
    check_output("after_reset");

    // End-to-end through the concat model.
    apply_stimulus(0, 16'hBEEF, 8'hEF, 8'hBE, 1'b1);
    check_output("end_to_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
